// File: rtl/int_ctrl.sv
// Prioritised edge-triggered interrupt controller driving the PC interrupt-jump path.
// Latency: irq edge at N -> pending at N+1 -> ARM at N+2 -> INTjmp at N+3 at the earliest.
// Backpressure: an armed interrupt waits in ARM until the CPU raises boundary; no nesting until reti.
module int_ctrl #(
    parameter int          NSRC      = 4,
    parameter logic [15:0] VEC_BASE  = 16'h0004,
    parameter int          VEC_SHIFT = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NSRC-1:0] irq,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            gie_set,
    input  logic            gie_clr,
    input  logic            boundary,
    input  logic            reti,
    output logic            INTjmp,
    output logic [15:0]     Aint,
    output logic [NSRC-1:0] mask,
    output logic            gie,
    output logic [NSRC-1:0] pending,
    output logic            int_active,
    output logic [2:0]      active_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        JUMP    = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [NSRC-1:0] irq_prev;
    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] pending_n;
    logic            gie_n;
    logic            intjmp_n;
    logic [15:0]     aint_n;
    logic [2:0]      active_id_n;
    logic [2:0]      winner;
    logic            any_elig;
    logic [15:0]     vec;

    assign edges      = irq & ~irq_prev;
    assign eligible   = pending & mask;
    assign any_elig   = |eligible;
    assign int_active = (state == SERVICE);

    // Lowest set index of the eligible sources wins; the vector wraps in 16 bits.
    always_comb begin
        winner = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
        vec = VEC_BASE + ({13'd0, winner} << VEC_SHIFT);
    end

    // Pending bits: the serviced bit clears in the JUMP cycle, but a fresh edge on it wins.
    always_comb begin
        clr_bits = '0;
        if (state == JUMP) begin
            clr_bits = NSRC'(1) << active_id;
        end
        pending_n = (pending & ~clr_bits) | edges;
    end

    // Global enable: the jump saves it by clearing, clear beats set, reti restores it.
    always_comb begin
        gie_n = gie;
        if (state == JUMP) begin
            gie_n = 1'b0;
        end else if (gie_clr) begin
            gie_n = 1'b0;
        end else if (gie_set || ((state == SERVICE) && reti)) begin
            gie_n = 1'b1;
        end
    end

    // Next state and registered jump outputs; the winner is re-picked every ARM cycle.
    always_comb begin
        state_n     = state;
        intjmp_n    = 1'b0;
        aint_n      = Aint;
        active_id_n = active_id;
        case (state)
            IDLE: begin
                if (gie && any_elig) begin
                    active_id_n = winner;
                    state_n     = ARM;
                end
            end
            ARM: begin
                if (!gie || !any_elig) begin
                    state_n = IDLE;
                end else begin
                    active_id_n = winner;
                    if (boundary) begin
                        intjmp_n = 1'b1;
                        aint_n   = vec;
                        state_n  = JUMP;
                    end
                end
            end
            JUMP: begin
                state_n = SERVICE;
            end
            SERVICE: begin
                if (reti) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: edge history, pending, mask, enable and jump outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            irq_prev  <= '0;
            pending   <= '0;
            mask      <= '0;
            gie       <= 1'b0;
            INTjmp    <= 1'b0;
            Aint      <= 16'h0000;
            active_id <= 3'd0;
        end else begin
            irq_prev  <= irq;
            pending   <= pending_n;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            gie       <= gie_n;
            INTjmp    <= intjmp_n;
            Aint      <= aint_n;
            active_id <= active_id_n;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: default-vector instance plus a wrap-around-vector instance.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Every wait on the design is bounded by a cycle budget.
module tb_int_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  irq = '0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wdata = '0;
    logic        gie_set = 1'b0;
    logic        gie_clr = 1'b0;
    logic        boundary = 1'b0;
    logic        reti = 1'b0;

    logic        INTjmp, INTjmp2;
    logic [15:0] Aint, Aint2;
    logic [3:0]  mask, mask2;
    logic        gie, gie2;
    logic [3:0]  pending, pending2;
    logic        int_active, int_active2;
    logic [2:0]  active_id, active_id2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    int_ctrl #(.NSRC(4), .VEC_BASE(16'h0004), .VEC_SHIFT(2)) dut (
        .CLK(CLK), .RST(RST), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .gie_set(gie_set), .gie_clr(gie_clr), .boundary(boundary), .reti(reti),
        .INTjmp(INTjmp), .Aint(Aint), .mask(mask), .gie(gie), .pending(pending),
        .int_active(int_active), .active_id(active_id)
    );

    int_ctrl #(.NSRC(4), .VEC_BASE(16'hFFFC), .VEC_SHIFT(2)) dut2 (
        .CLK(CLK), .RST(RST), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .gie_set(gie_set), .gie_clr(gie_clr), .boundary(boundary), .reti(reti),
        .INTjmp(INTjmp2), .Aint(Aint2), .mask(mask2), .gie(gie2), .pending(pending2),
        .int_active(int_active2), .active_id(active_id2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
        gie_set = 1'b0; gie_clr = 1'b0; boundary = 1'b0; reti = 1'b0;
        step(2);
        RST = 1'b0;
        step(1);
    endtask

    task automatic configure(input logic [3:0] m);
        mask_we = 1'b1; mask_wdata = m; gie_set = 1'b1;
        step(1);
        mask_we = 1'b0; gie_set = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        step(1);
        reti = 1'b0;
    endtask

    task automatic wait_jump(input int maxc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            step(1);
            if (INTjmp === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        int jc;
        do_reset();
        configure(4'b1111);
        boundary = 1'b0;
        irq = 4'b0010;
        step(2);
        tests++;
        if (active_id !== 3'd1 || pending !== 4'b0010) begin
            fails++; $display("FAIL reset_pre_arm: id=%0d pend=%b exp id=1 pend=0010", active_id, pending);
        end
        #2 RST = 1'b1;
        #1;
        tests++;
        if ({INTjmp, Aint, pending, mask, gie, int_active, active_id} !== 30'd0) begin
            fails++; $display("FAIL reset_outputs: jmp=%b aint=%h pend=%b mask=%b gie=%b act=%b id=%0d exp all zero",
                              INTjmp, Aint, pending, mask, gie, int_active, active_id);
        end
        boundary = 1'b1;
        step(1);
        RST = 1'b0;
        jc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (INTjmp === 1'b1) jc++;
        end
        tests++;
        if (jc !== 0 || mask !== 4'b0000) begin
            fails++; $display("FAIL reset_no_jump: jumps=%0d mask=%b exp jumps=0 mask=0000", jc, mask);
        end
        irq = '0; boundary = 1'b0;
    endtask

    task automatic test_basic_jump();
        do_reset();
        configure(4'b1111);
        tests++;
        if (mask !== 4'b1111 || gie !== 1'b1) begin
            fails++; $display("FAIL basic_cfg: mask=%b gie=%b exp 1111/1", mask, gie);
        end
        boundary = 1'b1;
        irq = 4'b0100;
        step(1);
        tests++;
        if (pending !== 4'b0100 || INTjmp !== 1'b0) begin
            fails++; $display("FAIL basic_pending: pend=%b jmp=%b exp 0100/0", pending, INTjmp);
        end
        step(1);
        tests++;
        if (INTjmp !== 1'b0 || active_id !== 3'd2) begin
            fails++; $display("FAIL basic_arm: jmp=%b id=%0d exp 0/2", INTjmp, active_id);
        end
        step(1);
        tests++;
        if (INTjmp !== 1'b1 || Aint !== 16'h000C) begin
            fails++; $display("FAIL basic_jmp: jmp=%b aint=%h exp 1/000c", INTjmp, Aint);
        end
        irq = '0;
        step(1);
        tests++;
        if (INTjmp !== 1'b0 || pending !== 4'b0000 || gie !== 1'b0 || int_active !== 1'b1 || Aint !== 16'h000C) begin
            fails++; $display("FAIL basic_service: jmp=%b pend=%b gie=%b act=%b aint=%h exp 0/0000/0/1/000c",
                              INTjmp, pending, gie, int_active, Aint);
        end
        pulse_reti();
        tests++;
        if (gie !== 1'b1 || int_active !== 1'b0 || INTjmp !== 1'b0) begin
            fails++; $display("FAIL basic_reti: gie=%b act=%b jmp=%b exp 1/0/0", gie, int_active, INTjmp);
        end
        boundary = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        configure(4'b1111);
        boundary = 1'b0;
        irq = 4'b1000;
        step(3);
        tests++;
        if (active_id !== 3'd3 || INTjmp !== 1'b0) begin
            fails++; $display("FAIL prio_arm3: id=%0d jmp=%b exp 3/0", active_id, INTjmp);
        end
        irq = 4'b1001;
        step(1);
        tests++;
        if (pending !== 4'b1001 || active_id !== 3'd3) begin
            fails++; $display("FAIL prio_pend: pend=%b id=%0d exp 1001/3", pending, active_id);
        end
        boundary = 1'b1;
        step(1);
        tests++;
        if (INTjmp !== 1'b1 || Aint !== 16'h0004 || active_id !== 3'd0) begin
            fails++; $display("FAIL prio_preempt: jmp=%b aint=%h id=%0d exp 1/0004/0", INTjmp, Aint, active_id);
        end
        irq = '0;
        step(1);
        tests++;
        if (pending !== 4'b1000 || int_active !== 1'b1) begin
            fails++; $display("FAIL prio_keep3: pend=%b act=%b exp 1000/1", pending, int_active);
        end
        pulse_reti();
        step(1);
        tests++;
        if (INTjmp !== 1'b0) begin
            fails++; $display("FAIL prio_gap: jmp=%b exp 0", INTjmp);
        end
        step(1);
        tests++;
        if (INTjmp !== 1'b1 || Aint !== 16'h0010 || active_id !== 3'd3) begin
            fails++; $display("FAIL prio_second: jmp=%b aint=%h id=%0d exp 1/0010/3", INTjmp, Aint, active_id);
        end
        step(1);
        pulse_reti();
        boundary = 1'b0;
    endtask

    task automatic test_masking();
        int jc;
        bit found;
        do_reset();
        configure(4'b1101);
        boundary = 1'b1;
        irq = 4'b0010;
        jc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (INTjmp === 1'b1) jc++;
        end
        tests++;
        if (jc !== 0 || pending !== 4'b0010) begin
            fails++; $display("FAIL mask_hold: jumps=%0d pend=%b exp 0/0010", jc, pending);
        end
        irq = '0;
        mask_we = 1'b1; mask_wdata = 4'b1111;
        step(1);
        mask_we = 1'b0;
        wait_jump(6, found);
        tests++;
        if (found !== 1'b1 || Aint !== 16'h0008) begin
            fails++; $display("FAIL mask_release: found=%b aint=%h exp 1/0008", found, Aint);
        end
        step(1);
        pulse_reti();
        tests++;
        if (gie !== 1'b1) begin
            fails++; $display("FAIL mask_gie_restore: gie=%b exp 1", gie);
        end
        gie_set = 1'b1; gie_clr = 1'b1;
        step(1);
        gie_set = 1'b0; gie_clr = 1'b0;
        tests++;
        if (gie !== 1'b0) begin
            fails++; $display("FAIL gie_clr_wins: gie=%b exp 0", gie);
        end
        boundary = 1'b0;
    endtask

    task automatic test_nesting();
        int jc;
        bit found;
        do_reset();
        configure(4'b1111);
        gie_clr = 1'b1;
        step(1);
        gie_clr = 1'b0;
        pulse_reti();
        tests++;
        if (gie !== 1'b0 || int_active !== 1'b0) begin
            fails++; $display("FAIL reti_idle_ignored: gie=%b act=%b exp 0/0", gie, int_active);
        end
        gie_set = 1'b1;
        step(1);
        gie_set = 1'b0;
        boundary = 1'b1;
        irq = 4'b0100;
        step(1);
        irq = '0;
        wait_jump(6, found);
        tests++;
        if (found !== 1'b1 || Aint !== 16'h000C) begin
            fails++; $display("FAIL nest_first: found=%b aint=%h exp 1/000c", found, Aint);
        end
        irq = 4'b0100;
        step(1);
        tests++;
        if (pending !== 4'b0100 || int_active !== 1'b1) begin
            fails++; $display("FAIL pend_collision: pend=%b act=%b exp 0100/1", pending, int_active);
        end
        irq = 4'b0001;
        step(1);
        tests++;
        if (pending !== 4'b0101) begin
            fails++; $display("FAIL nest_latch: pend=%b exp 0101", pending);
        end
        jc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (INTjmp === 1'b1) jc++;
        end
        tests++;
        if (jc !== 0 || int_active !== 1'b1) begin
            fails++; $display("FAIL no_nesting: jumps=%0d act=%b exp 0/1", jc, int_active);
        end
        irq = '0;
        pulse_reti();
        wait_jump(6, found);
        tests++;
        if (found !== 1'b1 || Aint !== 16'h0004 || active_id !== 3'd0) begin
            fails++; $display("FAIL nest_after_reti: found=%b aint=%h id=%0d exp 1/0004/0", found, Aint, active_id);
        end
        step(1);
        pulse_reti();
        wait_jump(6, found);
        tests++;
        if (found !== 1'b1 || Aint !== 16'h000C) begin
            fails++; $display("FAIL nest_refire: found=%b aint=%h exp 1/000c", found, Aint);
        end
        step(1);
        pulse_reti();
        boundary = 1'b0;
    endtask

    task automatic test_wrap();
        bit found;
        do_reset();
        configure(4'b1111);
        boundary = 1'b1;
        irq = 4'b0010;
        step(1);
        irq = '0;
        wait_jump(6, found);
        tests++;
        if (found !== 1'b1 || INTjmp2 !== 1'b1 || Aint2 !== 16'h0000) begin
            fails++; $display("FAIL wrap_vec: found=%b jmp2=%b aint2=%h exp 1/1/0000", found, INTjmp2, Aint2);
        end
        tests++;
        if (Aint !== 16'h0008) begin
            fails++; $display("FAIL wrap_ref: aint=%h exp 0008", Aint);
        end
        step(1);
        pulse_reti();
        boundary = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_jump();
        test_priority();
        test_masking();
        test_nesting();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
